// File: rtl/arch_register_pkg.sv
// ============================================================================
// arch_register_pkg : shared datapath constants for architectural registers
// Rev 1.0
// ============================================================================
`default_nettype none

package arch_register_pkg;

    localparam int unsigned ARCH_WIDTH = 32;
    localparam logic [ARCH_WIDTH-1:0] ARCH_RESET_VALUE = {ARCH_WIDTH{1'b0}};

endpackage : arch_register_pkg

`default_nettype wire

// File: rtl/arch_register.sv
// ============================================================================
// arch_register : WIDTH-bit architectural data register, clear > hold > load
// Rev 1.0
// ============================================================================
`default_nettype none

module arch_register
    import arch_register_pkg::*;
#(
    parameter int unsigned           WIDTH       = ARCH_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(ARCH_RESET_VALUE)
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (!hold_i) begin
            data_d = in_i;
        end
    end

    // Clear wins even while hold is asserted.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_o = data_q;

endmodule : arch_register

`default_nettype wire

// File: tb/tb_arch_register.sv
// ============================================================================
// tb_arch_register : directed scoreboard bench for arch_register
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arch_register;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    logic        clk;
    logic        clear;
    logic        hold;
    logic [31:0] din;
    logic [31:0] dout;

    sb_entry_t   sb_q[$];
    int          n_total;
    int          n_pass;

    arch_register u_dut (
        .clock_i (clk),
        .clear_i (clear),
        .hold_i  (hold),
        .in_i    (din),
        .out_o   (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 after the falling edge; the expectation pushed alongside
    // is the value out must show during this low phase, i.e. the result of
    // the previous rising edge, unaffected by the fresh input change.
    task automatic step(input logic c, input logic h, input logic [31:0] d,
                        input logic chk, input logic [31:0] exp, input string name);
        sb_entry_t e;
        @(negedge clk);
        #1;
        clear = c;
        hold  = h;
        din   = d;
        if (chk) begin
            e.exp  = exp;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: samples 3 after each falling edge, well clear of the rising edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_total++;
                if (dout === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: out=%h expected=%h", e.name, dout, e.exp);
                end
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        clear   = 1'b0;
        hold    = 1'b0;
        din     = 32'h0;

        step(1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,          "init");
        step(1'b0, 1'b0, 32'h0000_FFFF, 1'b1, 32'h0000_0000, "reset_state");
        step(1'b0, 1'b0, 32'h0000_00FF, 1'b1, 32'h0000_FFFF, "load_ffff");
        step(1'b0, 1'b0, 32'h1234_5678, 1'b1, 32'h0000_00FF, "load_ff_stable");
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "load_12345678");
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "hold_edge1");
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "hold_edge2");
        step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "hold_edge3");
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "release_hold_clear_midcycle");
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "sync_clear");
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "clear_beats_hold");
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "hold_after_clear1");
        step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "hold_after_clear2");
        step(1'b0, 1'b0, 32'hAAAA_AAAA, 1'b1, 32'hFFFF_FFFF, "load_all_ones");
        step(1'b0, 1'b0, 32'h5555_5555, 1'b1, 32'hAAAA_AAAA, "toggle_aaaa");
        step(1'b0, 1'b0, 32'hAAAA_AAAA, 1'b1, 32'h5555_5555, "toggle_5555");
        step(1'b0, 1'b0, 32'h8000_0000, 1'b1, 32'hAAAA_AAAA, "toggle_aaaa_again");
        step(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h8000_0000, "msb_only");
        step(1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h8000_0000, "msb_held");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #4;
        end
        while (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            n_total++;
            $display("FAIL %s: out=never_sampled expected=%h", e.name, e.exp);
        end

        @(negedge clk);
        #1;
        clear = 1'b0;
        hold  = 1'b0;
        din   = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        n_total++;
        if (dout === 32'hA5A5_0F0F) begin
            n_pass++;
        end else begin
            $display("FAIL direct_load: out=%h expected=%h", dout, 32'hA5A5_0F0F);
        end

        @(negedge clk);
        #1;
        din = 32'h0F0F_A5A5;
        #2;
        n_total++;
        if (dout === 32'hA5A5_0F0F) begin
            n_pass++;
        end else begin
            $display("FAIL direct_stable: out=%h expected=%h", dout, 32'hA5A5_0F0F);
        end

        clear = 1'b1;
        hold  = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (dout === 32'h0000_0000) begin
            n_pass++;
        end else begin
            $display("FAIL direct_clear_hold: out=%h expected=%h", dout, 32'h0000_0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_arch_register

`default_nettype wire

// File: doc/arch_register.md
Name: arch_register

Overview:
- General-purpose architectural data register of the processor datapath.
- Captures the `in` bus on each rising clock edge unless told to hold or clear.
- Basic storage element behind the register file and pipeline/state registers; drives its stored value continuously on `out`.

Parameters:
- WIDTH, default ARCH_WIDTH (32): data width of `in` and `out`.
- RESET_VALUE, default all zeros (WIDTH bits): value loaded when `clear` is asserted.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- hold  input  1  active-high hold; when high the stored value is retained.
- in  input  WIDTH  data to capture.
- out  output  WIDTH  current stored value, driven directly from the storage flops.

Behaviour:
- Single WIDTH-bit flop bank, rising-edge triggered on `clock`; no other state.
- Priority at each rising edge: clear > hold > load.
  - clear = 1: stored value becomes RESET_VALUE, regardless of hold and in.
  - clear = 0, hold = 1: stored value unchanged.
  - clear = 0, hold = 0: stored value becomes `in` as sampled at the edge.
- Latency: `out` reflects the new value immediately after the capturing edge (one-edge latency); no combinational path from `in` to `out`.
- `out` never changes between rising edges. Changes to in, hold or clear away from an edge have no effect.
- The falling edge has no effect.
- Reset value of `out`: RESET_VALUE after any edge with clear = 1. Before the first clear or load edge, contents are undefined; no power-on initialisation is required.
- Asserting clear while hold = 1 still resets. After clear deasserts, the register stays at RESET_VALUE while hold = 1.
- Full-width transfer; no sign extension, truncation or partial writes.

Decomposition:
- ARCH_WIDTH (32) lives in the shared constants package/include and is the default for WIDTH.
- RESET_VALUE default is expressed in terms of that constant's width.
- No sub-module; a single always block on the rising clock edge is sufficient.
- Reused unmodified by registers/register-file logic.

Test Plan:
- Load: clear = 0, hold = 0, in = 32'h0000FFFF, rising edge → out = 32'h0000FFFF. Then in = 32'h000000FF at the falling edge, next rising edge → out = 32'h000000FF.
- Stability between edges: out = 32'h000000FF; change in to 32'h12345678 while clock is low, then on the falling edge → out stays 32'h000000FF until the next rising edge, then becomes 32'h12345678.
- Hold: out = 32'h12345678, hold = 1, in = 32'hDEADBEEF, three rising edges → out stays 32'h12345678. Then hold = 0, one edge → out = 32'hDEADBEEF.
- Synchronous clear: out = 32'hDEADBEEF, assert clear mid-cycle → out unchanged until the next rising edge, then out = 32'h00000000.
- Priority: clear = 1, hold = 1, in = 32'hFFFFFFFF, rising edge → out = 0. Then clear = 0 with hold = 1 → out stays 0. Then hold = 0 → out = 32'hFFFFFFFF.
- Width/boundary: alternate in = 32'hAAAAAAAA / 32'h55555555 on consecutive edges with hold = 0 → out toggles all bits correctly. Check that bit 31 is captured and there is no truncation.
